// File: rtl/lcd_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lcd_ctrl_pkg
// Shared definitions for the 8x8 image display controller: image geometry,
// pixel/coordinate/address types, command codes, controller states and the
// small helpers used to form buffer addresses and classify commands.
// ----------------------------------------------------------------------------
package lcd_ctrl_pkg;

    localparam int IMG_W  = 8;                 // image width and height
    localparam int PIX_W  = 8;                 // pixel bit width
    localparam int CRD_W  = $clog2(IMG_W);     // bits per coordinate
    localparam int ADDR_W = 2 * CRD_W;         // row-major pixel address
    localparam int PIX_N  = IMG_W * IMG_W;     // pixels in the image

    typedef logic [CRD_W-1:0]  crd_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PIX_W-1:0]  pix_t;

    // Operation point limits; the window spans (px-1..px, py-1..py).
    localparam crd_t  INIT_PX   = crd_t'(4);
    localparam crd_t  INIT_PY   = crd_t'(4);
    localparam crd_t  PMIN      = crd_t'(1);
    localparam crd_t  PMAX      = crd_t'(IMG_W - 1);
    localparam addr_t LAST_ADDR = addr_t'(PIX_N - 1);

    typedef enum logic [3:0] {
        CMD_WRITE    = 4'd0,
        CMD_UP       = 4'd1,
        CMD_DOWN     = 4'd2,
        CMD_LEFT     = 4'd3,
        CMD_RIGHT    = 4'd4,
        CMD_MAX      = 4'd5,
        CMD_MIN      = 4'd6,
        CMD_AVG      = 4'd7,
        CMD_ROT_CCW  = 4'd8,
        CMD_ROT_CW   = 4'd9,
        CMD_MIRROR_X = 4'd10,
        CMD_MIRROR_Y = 4'd11
    } cmd_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        IDLE  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Row-major address y*IMG_W + x; IMG_W is a power of two so this is a
    // plain concatenation.
    function automatic addr_t pix_addr(input crd_t x, input crd_t y);
        return {y, x};
    endfunction

    // Commands that rewrite the four window pixels.
    function automatic logic is_win_op(input logic [3:0] c);
        return (c >= CMD_MAX) && (c <= CMD_MIRROR_Y);
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// ----------------------------------------------------------------------------
// lcd_win_alu
// Combinational 2x2 window transform. Given the four pixels under the
// operation window and the current command, returns the four replacement
// pixels. Commands that do not touch pixels pass the inputs through.
//
// Ports:
//   cmd                     in   4      command code
//   tl, tr, bl, br          in   PIX_W  top-left/top-right/bottom-left/bottom-right
//   new_tl .. new_br        out  PIX_W  replacement pixels
// ----------------------------------------------------------------------------
module lcd_win_alu
    import lcd_ctrl_pkg::*;
(
    input  logic [3:0]       cmd,
    input  logic [PIX_W-1:0] tl,
    input  logic [PIX_W-1:0] tr,
    input  logic [PIX_W-1:0] bl,
    input  logic [PIX_W-1:0] br,
    output logic [PIX_W-1:0] new_tl,
    output logic [PIX_W-1:0] new_tr,
    output logic [PIX_W-1:0] new_bl,
    output logic [PIX_W-1:0] new_br
);

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    pix_t             win_max;
    pix_t             win_min;
    pix_t             win_avg;
    logic [PIX_W+1:0] win_sum;   // two extra bits hold the sum of four pixels

    always_comb begin
        win_max = max2(max2(tl, tr), max2(bl, br));
        win_min = min2(min2(tl, tr), min2(bl, br));
        win_sum = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
        win_avg = win_sum[PIX_W+1:2];   // floor(sum / 4)

        new_tl = tl;
        new_tr = tr;
        new_bl = bl;
        new_br = br;

        case (cmd)
            CMD_MAX: begin
                new_tl = win_max;
                new_tr = win_max;
                new_bl = win_max;
                new_br = win_max;
            end
            CMD_MIN: begin
                new_tl = win_min;
                new_tr = win_min;
                new_bl = win_min;
                new_br = win_min;
            end
            CMD_AVG: begin
                new_tl = win_avg;
                new_tr = win_avg;
                new_bl = win_avg;
                new_br = win_avg;
            end
            CMD_ROT_CCW: begin
                new_tl = tr;
                new_tr = br;
                new_br = bl;
                new_bl = tl;
            end
            CMD_ROT_CW: begin
                new_tl = bl;
                new_tr = tl;
                new_br = tr;
                new_bl = br;
            end
            CMD_MIRROR_X: begin
                new_tl = bl;
                new_bl = tl;
                new_tr = br;
                new_br = tr;
            end
            CMD_MIRROR_Y: begin
                new_tl = tr;
                new_tr = tl;
                new_bl = br;
                new_br = bl;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_ctrl
// 8x8 image display controller. After reset the image is copied from IROM
// into an internal 64-pixel buffer; afterwards 4-bit commands move a 2x2
// operation window or transform the pixels beneath it, and the Write command
// streams the whole buffer to IRAM followed by a one-cycle done pulse.
//
// Ports:
//   clk         in   1   rising-edge clock (external memories use falling edge)
//   reset       in   1   asynchronous, active-low
//   cmd         in   4   command code, taken when cmd_valid=1 and busy=0
//   cmd_valid   in   1   command strobe
//   IROM_rd     out  1   IROM read enable (high only while loading)
//   IROM_A      out  6   IROM address
//   IROM_Q      in   8   IROM data for the current IROM_A
//   IRAM_valid  out  1   IRAM write enable
//   IRAM_A      out  6   IRAM write address
//   IRAM_D      out  8   IRAM write data
//   busy        out  1   high while a command cannot be accepted
//   done        out  1   one-cycle pulse after the last IRAM write
// ----------------------------------------------------------------------------
module lcd_ctrl
    import lcd_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              IROM_rd,
    output logic [ADDR_W-1:0] IROM_A,
    input  logic [PIX_W-1:0]  IROM_Q,
    output logic              IRAM_valid,
    output logic [ADDR_W-1:0] IRAM_A,
    output logic [PIX_W-1:0]  IRAM_D,
    output logic              busy,
    output logic              done
);

    state_t     state;
    crd_t       px;
    crd_t       py;
    logic [3:0] cmd_r;

    pix_t       img [PIX_N];

    addr_t      tl_a, tr_a, bl_a, br_a;
    addr_t      wr_next;
    pix_t       tl, tr, bl, br;
    pix_t       new_tl, new_tr, new_bl, new_br;
    logic       win_wr;

    // Window corners relative to the operation point (px,py), which always
    // lies in 1..7 so px-1 / py-1 never underflow.
    assign tl_a = pix_addr(px - crd_t'(1), py - crd_t'(1));
    assign tr_a = pix_addr(px,             py - crd_t'(1));
    assign bl_a = pix_addr(px - crd_t'(1), py);
    assign br_a = pix_addr(px,             py);

    assign tl = img[tl_a];
    assign tr = img[tr_a];
    assign bl = img[bl_a];
    assign br = img[br_a];

    assign win_wr  = (state == EXEC) && is_win_op(cmd_r);
    assign wr_next = IRAM_A + addr_t'(1);

    lcd_win_alu u_alu (
        .cmd    (cmd_r),
        .tl     (tl),
        .tr     (tr),
        .bl     (bl),
        .br     (br),
        .new_tl (new_tl),
        .new_tr (new_tr),
        .new_bl (new_bl),
        .new_br (new_br)
    );

    // Image buffer carries no reset: every reset is followed by a full reload.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            img[IROM_A] <= IROM_Q;
        end else if (win_wr) begin
            img[tl_a] <= new_tl;
            img[tr_a] <= new_tr;
            img[bl_a] <= new_bl;
            img[br_a] <= new_br;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            px         <= INIT_PX;
            py         <= INIT_PY;
            cmd_r      <= 4'd0;
            IROM_rd    <= 1'b1;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_A     <= '0;
            IRAM_D     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    // IROM_Q was fetched on the previous falling edge from
                    // the current IROM_A; the buffer captures it this edge.
                    IROM_A <= IROM_A + addr_t'(1);
                    if (IROM_A == LAST_ADDR) begin
                        IROM_rd <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                IDLE: begin
                    if (cmd_valid) begin
                        cmd_r <= cmd;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    case (cmd_r)
                        CMD_WRITE: begin
                            // Present address 0 now so the first IRAM write
                            // lands on the coming falling edge.
                            busy       <= 1'b1;
                            state      <= WRITE;
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= img[0];
                        end
                        CMD_UP:    if (py > PMIN) py <= py - crd_t'(1);
                        CMD_DOWN:  if (py < PMAX) py <= py + crd_t'(1);
                        CMD_LEFT:  if (px > PMIN) px <= px - crd_t'(1);
                        CMD_RIGHT: if (px < PMAX) px <= px + crd_t'(1);
                        default: ;   // pixel ops handled by the buffer block
                    endcase
                end

                WRITE: begin
                    if (IRAM_A == LAST_ADDR) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        IRAM_A <= wr_next;
                        IRAM_D <= img[wr_next];
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lcd_ctrl
// Bench for lcd_ctrl: falling-edge IROM/IRAM models, an image/window model
// updated per accepted command, a per-cycle checker on the IRAM stream and
// done pulse, directed scenarios with literal expectations, and a random
// command phase.
// ----------------------------------------------------------------------------
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q = 8'd0;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    lcd_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IROM_Q     (IROM_Q),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .busy       (busy),
        .done       (done)
    );

    logic [7:0] rom  [64];
    logic [7:0] iram [64];
    logic [7:0] mimg [64];   // expected buffer contents
    int         mpx, mpy;    // expected operation point
    int         total = 0;
    int         bad = 0;
    int         wr_exp = 0;
    int         done_cnt = 0;

    // External memories act on the falling edge.
    always @(negedge clk) begin
        if (IROM_rd) IROM_Q <= rom[IROM_A];
        if (IRAM_valid) iram[IRAM_A] = IRAM_D;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural effect of one accepted command on the model.
    task automatic model_apply(input logic [3:0] c);
        int       a [4];
        logic [7:0] p [4];
        logic [7:0] q [4];
        int       s, mx, mn;
        a[0] = (mpy - 1) * 8 + (mpx - 1);   // TL
        a[1] = (mpy - 1) * 8 + mpx;         // TR
        a[2] = mpy * 8 + (mpx - 1);         // BL
        a[3] = mpy * 8 + mpx;               // BR
        s = 0; mx = 0; mn = 255;
        for (int i = 0; i < 4; i++) begin
            p[i] = mimg[a[i]];
            q[i] = p[i];
            s += int'(p[i]);
            if (int'(p[i]) > mx) mx = int'(p[i]);
            if (int'(p[i]) < mn) mn = int'(p[i]);
        end
        case (c)
            4'd1: if (mpy > 1) mpy--;
            4'd2: if (mpy < 7) mpy++;
            4'd3: if (mpx > 1) mpx--;
            4'd4: if (mpx < 7) mpx++;
            4'd5: for (int i = 0; i < 4; i++) q[i] = 8'(mx);
            4'd6: for (int i = 0; i < 4; i++) q[i] = 8'(mn);
            4'd7: for (int i = 0; i < 4; i++) q[i] = 8'(s / 4);
            4'd8: begin q[0] = p[1]; q[1] = p[3]; q[3] = p[2]; q[2] = p[0]; end
            4'd9: begin q[0] = p[2]; q[1] = p[0]; q[3] = p[1]; q[2] = p[3]; end
            4'd10: begin q[0] = p[2]; q[2] = p[0]; q[1] = p[3]; q[3] = p[1]; end
            4'd11: begin q[0] = p[1]; q[1] = p[0]; q[2] = p[3]; q[3] = p[2]; end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) mimg[a[i]] = q[i];
    endtask

    // Per-cycle check of the write stream and done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            wr_exp = 0;
        end else begin
            if (IRAM_valid) begin
                chk("iram_addr", 32'(IRAM_A), wr_exp);
                chk("iram_data", 32'(IRAM_D), 32'(mimg[IRAM_A]));
                wr_exp++;
            end
            if (done) begin
                chk("done_after_last_addr", wr_exp, 64);
                chk("busy_at_done", 32'(busy), 0);
                wr_exp = 0;
                done_cnt++;
            end
        end
    end

    task automatic do_reset();
        int n;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mimg[i] = rom[i];
        mpx = 4;
        mpy = 4;
        #1;
        chk("rst_IROM_rd", 32'(IROM_rd), 1);
        chk("rst_IROM_A", 32'(IROM_A), 0);
        chk("rst_IRAM_valid", 32'(IRAM_valid), 0);
        chk("rst_IRAM_A", 32'(IRAM_A), 0);
        chk("rst_IRAM_D", 32'(IRAM_D), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 200);
        chk("load_cycles", n, 64);
        chk("IROM_rd_after_load", 32'(IROM_rd), 0);
    endtask

    task automatic send_cmd(input logic [3:0] c, input bit wait_done);
        int n, d0;
        @(negedge clk);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("cmd_wait_timeout", 32'(busy), 0);
            return;
        end
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 1);
        model_apply(c);
        if (c == 4'd0 && wait_done) begin
            for (int i = 0; i < 64; i++) iram[i] = 'x;
            d0 = done_cnt;
            n = 0;
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("done_seen", 32'(done), 1);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 0);
            chk("done_count", done_cnt - d0, 1);
            for (int i = 0; i < 64; i++) chk("iram_vs_model", 32'(iram[i]), 32'(mimg[i]));
        end
    endtask

    task automatic rand_rom();
        for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Identity image, full write, then Max at the initial window.
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
        #2 do_reset();
        send_cmd(4'd0, 1);
        for (int i = 0; i < 64; i++) chk("identity_write", 32'(iram[i]), i);
        send_cmd(4'd5, 0);
        send_cmd(4'd0, 1);
        chk("max_27", 32'(iram[27]), 36);
        chk("max_28", 32'(iram[28]), 36);
        chk("max_35", 32'(iram[35]), 36);
        chk("max_36", 32'(iram[36]), 36);
        chk("max_keep_26", 32'(iram[26]), 26);
        chk("max_keep_37", 32'(iram[37]), 37);

        // Average and Min on 10,20,30,41.
        rand_rom();
        rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd41;
        do_reset();
        send_cmd(4'd7, 0);
        send_cmd(4'd0, 1);
        chk("avg_27", 32'(iram[27]), 25);
        chk("avg_28", 32'(iram[28]), 25);
        chk("avg_35", 32'(iram[35]), 25);
        chk("avg_36", 32'(iram[36]), 25);
        do_reset();
        send_cmd(4'd6, 0);
        send_cmd(4'd0, 1);
        chk("min_27", 32'(iram[27]), 10);
        chk("min_36", 32'(iram[36]), 10);

        // Shift up to the top edge, rotate CW then CCW.
        rand_rom();
        rom[3] = 8'd1; rom[4] = 8'd2; rom[11] = 8'd3; rom[12] = 8'd4;
        do_reset();
        repeat (5) send_cmd(4'd1, 0);
        send_cmd(4'd9, 0);
        send_cmd(4'd0, 1);
        chk("rotcw_tl", 32'(iram[3]), 3);
        chk("rotcw_tr", 32'(iram[4]), 1);
        chk("rotcw_bl", 32'(iram[11]), 4);
        chk("rotcw_br", 32'(iram[12]), 2);
        send_cmd(4'd8, 0);
        send_cmd(4'd0, 1);
        chk("rotccw_tl", 32'(iram[3]), 1);
        chk("rotccw_tr", 32'(iram[4]), 2);
        chk("rotccw_bl", 32'(iram[11]), 3);
        chk("rotccw_br", 32'(iram[12]), 4);

        // Right edge mirrors, then left edge Max.
        rand_rom();
        rom[30] = 8'd1; rom[31] = 8'd2; rom[38] = 8'd3; rom[39] = 8'd4;
        rom[24] = 8'd5; rom[25] = 8'd200; rom[32] = 8'd7; rom[33] = 8'd9;
        do_reset();
        repeat (5) send_cmd(4'd4, 0);
        send_cmd(4'd11, 0);
        send_cmd(4'd0, 1);
        chk("miry_tl", 32'(iram[30]), 2);
        chk("miry_tr", 32'(iram[31]), 1);
        chk("miry_bl", 32'(iram[38]), 4);
        chk("miry_br", 32'(iram[39]), 3);
        send_cmd(4'd10, 0);
        send_cmd(4'd0, 1);
        chk("mirx_tl", 32'(iram[30]), 4);
        chk("mirx_tr", 32'(iram[31]), 3);
        chk("mirx_bl", 32'(iram[38]), 2);
        chk("mirx_br", 32'(iram[39]), 1);
        repeat (10) send_cmd(4'd3, 0);
        send_cmd(4'd5, 0);
        send_cmd(4'd0, 1);
        chk("left_max_24", 32'(iram[24]), 200);
        chk("left_max_25", 32'(iram[25]), 200);
        chk("left_max_32", 32'(iram[32]), 200);
        chk("left_max_33", 32'(iram[33]), 200);

        // cmd_valid held high with a no-op code.
        @(negedge clk);
        while (busy) @(negedge clk);
        cmd = 4'd13;
        cmd_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("hold_busy", 32'(busy), (k % 2 == 0) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        send_cmd(4'd0, 1);

        // Random command sequence.
        rand_rom();
        do_reset();
        for (int t = 0; t < 300; t++) begin
            logic [3:0] c;
            c = 4'($urandom_range(1, 15));
            if (t % 25 == 24) c = 4'd0;
            send_cmd(c, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        send_cmd(4'd0, 1);

        // Reset in the middle of a write stream, then reload.
        send_cmd(4'd0, 0);
        repeat (10) @(posedge clk);
        #2;
        chk("stream_active", 32'(IRAM_valid), 1);
        rand_rom();
        do_reset();
        send_cmd(4'd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
